// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with a one-entry skid buffer.
// in_ready is a flop, so it never combinationally depends on out_ready.
// The stage also inserts bubbles (control zeroed when invalid), supports flush,
// and provides a destination-register hazard compare.
// Optional feature macro: PIPE_STATS_EN adds saturating stall/bubble counters.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// Once out_valid rises, out_data/out_ctrl/out_dst hold steady until out_ready
// accepts the entry. in_ready is taken as an offer for the current cycle and does
// not depend on in_valid.
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 10,
   parameter int REG_W  = 3,
   parameter int WR_BIT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [REG_W-1:0]  in_dst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [REG_W-1:0]  out_dst,
   input  logic [REG_W-1:0]  chk_rs,
   input  logic [REG_W-1:0]  chk_rt,
   output logic              hit_rs,
   output logic              hit_rt,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       bubble_cnt,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_in_ready;
   logic [DATA_W-1:0] r_main_data;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [REG_W-1:0]  r_main_dst;
   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [REG_W-1:0]  r_skid_dst;

   logic w_xfer_in;
   logic w_xfer_out;
   logic w_out_valid;
   logic w_load_main_in;
   logic w_load_main_skid;
   logic w_load_skid;

   assign w_xfer_in   = in_valid & r_in_ready;
   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_xfer_out  = w_out_valid & out_ready;

   // State register; in_ready is precomputed from the next state so it is a flop
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_next_state;
         r_in_ready <= (w_next_state != ST_SKID);
      end
   end

   // Next-state logic; flush overrides every handshake outcome
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_EMPTY: if (w_xfer_in) w_next_state = ST_FULL;
         ST_FULL: begin
            if (w_xfer_in && !w_xfer_out)      w_next_state = ST_SKID;
            else if (!w_xfer_in && w_xfer_out) w_next_state = ST_EMPTY;
         end
         ST_SKID:  if (w_xfer_out) w_next_state = ST_FULL;
         default:  w_next_state = ST_EMPTY;
      endcase
      if (flush) w_next_state = ST_EMPTY;
   end

   // Datapath load enables per state; flush drops the concurrent input
   always_comb begin
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (!flush) begin
         case (r_state)
            ST_EMPTY: w_load_main_in = w_xfer_in;
            ST_FULL: begin
               w_load_main_in = w_xfer_in & w_xfer_out;
               w_load_skid    = w_xfer_in & ~w_xfer_out;
            end
            ST_SKID:  w_load_main_skid = w_xfer_out;
            default: ;
         endcase
      end
   end

   // Main entry: filled from the input, or from the skid slot when it drains
   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_data <= '0;
         r_main_ctrl <= '0;
         r_main_dst  <= '0;
      end else if (w_load_main_in) begin
         r_main_data <= in_data;
         r_main_ctrl <= in_ctrl;
         r_main_dst  <= in_dst;
      end else if (w_load_main_skid) begin
         r_main_data <= r_skid_data;
         r_main_ctrl <= r_skid_ctrl;
         r_main_dst  <= r_skid_dst;
      end
   end

   // Skid entry: catches the input accepted while main is stalled downstream
   always_ff @(posedge clk) begin
      if (rst) begin
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_dst  <= '0;
      end else if (w_load_skid) begin
         r_skid_data <= in_data;
         r_skid_ctrl <= in_ctrl;
         r_skid_dst  <= in_dst;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = w_out_valid;
   assign out_data  = r_main_data;
   assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
   assign out_dst   = r_main_dst;
   assign dbg_state = r_state;

   // out_ctrl is already zero for a bubble, so a stale out_dst cannot raise a hit
   assign hit_rs = w_out_valid & out_ctrl[WR_BIT] & (r_main_dst == chk_rs);
   assign hit_rt = w_out_valid & out_ctrl[WR_BIT] & (r_main_dst == chk_rt);

`ifdef PIPE_STATS_EN
   logic [15:0] r_stall_cnt;
   logic [15:0] r_bubble_cnt;

   // Saturating stats counters; only reset clears them, flush leaves them alone
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt  <= 16'h0000;
         r_bubble_cnt <= 16'h0000;
      end else begin
         if (w_out_valid && !out_ready && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'h0001;
         if (!w_out_valid && r_bubble_cnt != 16'hFFFF)
            r_bubble_cnt <= r_bubble_cnt + 16'h0001;
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
`else
   assign stall_cnt  = 16'h0000;
   assign bubble_cnt = 16'h0000;
`endif

endmodule
